// File: rtl/fifo_stream_reader.sv
// Read-side adapter for a registered-output FIFO: prefetches up to three words
// and presents them as a valid/ready stream without any m_ready -> rd_en path.
module fifo_stream_reader #(
  parameter int W     = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  output logic             fifo_rd_en_o,
  input  logic [W-1:0]     fifo_dout_i,
  input  logic             fifo_empty_i,
  output logic             m_valid_o,
  input  logic             m_ready_i,
  output logic [W-1:0]     m_data_o,
  output logic [1:0]       buf_level_o,
  output logic [CNT_W-1:0] words_out_o
);

  logic [W-1:0]     buf_q [3];
  logic [W-1:0]     buf_d [3];
  logic [1:0]       rd_ptr_q, rd_ptr_d;
  logic [1:0]       wr_ptr_q, wr_ptr_d;
  logic [1:0]       occ_q, occ_d;
  logic             inflight_q, inflight_d;
  logic [CNT_W-1:0] words_out_q, words_out_d;
  logic             space_ok;
  logic             handshake;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // A read is issued only if the word it returns is guaranteed a free slot.
  always_comb begin
    space_ok     = ({1'b0, occ_q} + {2'b00, inflight_q}) < 3'd3;
    fifo_rd_en_o = !rst_i && en_i && !fifo_empty_i && space_ok;
    m_valid_o    = !rst_i && (occ_q != 2'd0);
    m_data_o     = rst_i ? '0 : buf_q[rd_ptr_q];
    buf_level_o  = rst_i ? 2'd0 : occ_q;
    words_out_o  = words_out_q;
    handshake    = m_valid_o && m_ready_i;
  end

  always_comb begin
    buf_d       = buf_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    words_out_d = words_out_q;
    inflight_d  = fifo_rd_en_o;
    if (inflight_q) begin
      buf_d[wr_ptr_q] = fifo_dout_i;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (handshake) begin
      rd_ptr_d    = ptr_inc(rd_ptr_q);
      words_out_d = words_out_q + CNT_W'(1);
    end
    occ_d = occ_q + {1'b0, inflight_q} - {1'b0, handshake};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      buf_q       <= '{default: '0};
      rd_ptr_q    <= 2'd0;
      wr_ptr_q    <= 2'd0;
      occ_q       <= 2'd0;
      inflight_q  <= 1'b0;
      words_out_q <= '0;
    end else begin
      buf_q       <= buf_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      occ_q       <= occ_d;
      inflight_q  <= inflight_d;
      words_out_q <= words_out_d;
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: behavioural FIFO, occupancy model and a
// scoreboard of FIFO write order checked by an independent negedge monitor.
module tb_fifo_stream_reader;
  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1, en = 1'b1, m_ready = 1'b0;
  logic         fifo_empty = 1'b1, fifo_clr = 1'b0, wr_req = 1'b0;
  logic [W-1:0] fifo_dout = '0, wr_data = '0;

  logic         fifo_rd_en, m_valid, rd_en4, m_valid4;
  logic [W-1:0] m_data, m_data4;
  logic [1:0]   buf_level, buf_level4;
  logic [15:0]  words_out;
  logic [3:0]   words_out4;

  fifo_stream_reader #(.W(W), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .fifo_rd_en_o(fifo_rd_en),
    .fifo_dout_i(fifo_dout), .fifo_empty_i(fifo_empty), .m_valid_o(m_valid),
    .m_ready_i(m_ready), .m_data_o(m_data), .buf_level_o(buf_level),
    .words_out_o(words_out));

  fifo_stream_reader #(.W(W), .CNT_W(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .fifo_rd_en_o(rd_en4),
    .fifo_dout_i(fifo_dout), .fifo_empty_i(fifo_empty), .m_valid_o(m_valid4),
    .m_ready_i(m_ready), .m_data_o(m_data4), .buf_level_o(buf_level4),
    .words_out_o(words_out4));

  int checks = 0, errors = 0;
  logic [W-1:0] fifo_q[$];
  logic [W-1:0] exp_q[$];
  int occ_m = 0, inflight_m = 0, words_cnt = 0, rd_count = 0;
  bit mon_on = 1'b0;
  bit prev_valid = 1'b0, prev_ready = 1'b0, prev_rst = 1'b1;
  logic [W-1:0] prev_data = '0;

  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // FIFO with registered dout: popped word appears one edge after rd_en.
  always @(posedge clk) begin
    if (fifo_clr) begin
      fifo_q.delete();
      exp_q.delete();
    end else begin
      if (fifo_rd_en) begin
        if (fifo_q.size() > 0) fifo_dout <= fifo_q.pop_front();
        else begin
          errors++;
          $display("FAIL fifo_underflow: read issued with FIFO empty at %0t", $time);
        end
        rd_count++;
      end
      if (wr_req) begin
        fifo_q.push_back(wr_data);
        exp_q.push_back(wr_data);
      end
    end
    fifo_empty <= (fifo_q.size() == 0);
  end

  // Occupancy model: words held = delivered reads - accepted words.
  always @(posedge clk) begin
    bit hs;
    if (rst) begin
      occ_m = 0; inflight_m = 0; words_cnt = 0;
    end else begin
      hs = (occ_m != 0) && m_ready;
      occ_m = occ_m + inflight_m - (hs ? 1 : 0);
      inflight_m = fifo_rd_en ? 1 : 0;
      if (hs) words_cnt++;
    end
  end

  always @(negedge clk) begin
    bit exp_rd;
    logic [W-1:0] ed;
    if (mon_on) begin
      if (rst) begin
        chk(!fifo_rd_en, "rst_rd_en", fifo_rd_en, 0);
        chk(!m_valid, "rst_m_valid", m_valid, 0);
        chk(m_data == '0, "rst_m_data", m_data, 0);
        chk(buf_level == 2'd0, "rst_buf_level", buf_level, 0);
        if (prev_rst) begin
          chk(words_out == 16'd0, "rst_words_out", words_out, 0);
          chk(words_out4 == 4'd0, "rst_words_out4", words_out4, 0);
        end
      end else begin
        exp_rd = en && !fifo_empty && (occ_m + inflight_m < 3);
        chk(fifo_rd_en == exp_rd, "rd_en", fifo_rd_en, exp_rd);
        chk(rd_en4 == exp_rd, "rd_en4", rd_en4, exp_rd);
        chk(m_valid == (occ_m != 0), "m_valid", m_valid, occ_m != 0);
        chk(m_valid4 == (occ_m != 0), "m_valid4", m_valid4, occ_m != 0);
        chk(buf_level == occ_m, "buf_level", buf_level, occ_m);
        chk(buf_level4 == occ_m, "buf_level4", buf_level4, occ_m);
        chk(words_out == 16'(words_cnt), "words_out", words_out, words_cnt % 65536);
        chk(words_out4 == 4'(words_cnt), "words_out4", words_out4, words_cnt % 16);
        if (prev_valid && !prev_ready && !prev_rst)
          chk(m_valid && m_data == prev_data, "hold_data", m_data, prev_data);
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_extra: unexpected word %0h at %0t", m_data, $time);
          end else begin
            ed = exp_q.pop_front();
            chk(m_data == ed, "sb_data", m_data, ed);
            chk(m_data4 == ed, "sb_data4", m_data4, ed);
          end
        end
      end
      prev_valid = m_valid; prev_ready = m_ready; prev_rst = rst; prev_data = m_data;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin tick(); n++; end
    chk(exp_q.size() == 0, name, exp_q.size(), 0);
  endtask

  task automatic write_words(input int cnt, input logic [W-1:0] base);
    wr_req = 1'b1;
    for (int i = 0; i < cnt; i++) begin
      wr_data = base + W'(i);
      tick();
    end
    wr_req = 1'b0;
  endtask

  initial begin
    int n, hs_n, rd0, sent;
    tick();
    mon_on = 1'b1;
    // reset held while FIFO holds data; those words must survive the reset
    write_words(3, 8'h30);
    tick(); tick();
    rst = 1'b0; m_ready = 1'b1;
    wait_drain("t1_drain");
    rst = 1'b1; fifo_clr = 1'b1; tick(); tick(); rst = 1'b0; fifo_clr = 1'b0;

    // latency
    wr_req = 1'b1; wr_data = 8'hA5; tick(); wr_req = 1'b0;
    @(negedge clk); chk(fifo_rd_en == 1'b1, "t2_rd_en", fifo_rd_en, 1);
    tick(); @(negedge clk); chk(m_valid == 1'b0, "t2_not_yet", m_valid, 0);
    tick(); @(negedge clk); chk(m_valid && m_data == 8'hA5, "t2_first", m_data, 8'hA5);
    tick(); @(negedge clk); chk(words_out == 16'd1, "t2_words", words_out, 1);
    tick();

    // throughput
    en = 1'b0; write_words(16, 8'h00); en = 1'b1; m_ready = 1'b1;
    n = 0;
    while (!m_valid && n < 20) begin @(negedge clk); n++; end
    hs_n = 0;
    for (int k = 0; k < 16; k++) begin
      if (m_valid && m_ready) hs_n++;
      @(negedge clk);
    end
    chk(hs_n == 16, "t3_no_bubbles", hs_n, 16);
    chk(words_out == 16'd17, "t3_words", words_out, 17);
    @(posedge clk); #1;

    // backpressure
    m_ready = 1'b0; rd0 = rd_count;
    write_words(8, 8'h80);
    repeat (4) tick();
    @(negedge clk);
    chk(rd_count - rd0 == 3, "t4_reads", rd_count - rd0, 3);
    chk(buf_level == 2'd3, "t4_level", buf_level, 3);
    chk(m_data == 8'h80, "t4_head", m_data, 8'h80);
    tick(); m_ready = 1'b1;
    wait_drain("t4_drain");
    @(negedge clk); chk(words_out == 16'd25, "t4_words", words_out, 25);
    tick();

    // random traffic
    sent = 0; n = 0;
    while ((sent < 1000 || exp_q.size() != 0) && n < 20000) begin
      wr_req = (sent < 1000) && ($urandom_range(0, 3) != 0);
      if (wr_req) begin wr_data = W'($urandom); sent++; end
      m_ready = $urandom_range(0, 1) != 0;
      en = $urandom_range(0, 9) != 0;
      tick(); n++;
    end
    wr_req = 1'b0; en = 1'b1; m_ready = 1'b1;
    chk(exp_q.size() == 0 && sent == 1000, "t5_complete", sent, 1000);
    @(negedge clk); chk(words_out == 16'd1025, "t5_words", words_out, 1025);
    tick();

    // en dropped with one read in flight
    m_ready = 1'b0; en = 1'b0;
    write_words(2, 8'hC1);
    rd0 = rd_count; en = 1'b1; tick(); en = 1'b0;
    tick(); tick();
    @(negedge clk);
    chk(rd_count - rd0 == 1, "t6_one_read", rd_count - rd0, 1);
    chk(buf_level == 2'd1, "t6_captured", buf_level, 1);
    chk(m_data == 8'hC1, "t6_data", m_data, 8'hC1);
    chk(fifo_q.size() == 1, "t6_fifo_left", fifo_q.size(), 1);
    tick(); en = 1'b1; m_ready = 1'b1;
    wait_drain("t6_drain");

    // reset with two words buffered
    m_ready = 1'b0;
    write_words(2, 8'hD1);
    n = 0;
    while (buf_level != 2'd2 && n < 10) begin tick(); n++; end
    chk(buf_level == 2'd2, "t6_level2", buf_level, 2);
    rst = 1'b1; fifo_clr = 1'b1; tick();
    @(negedge clk); chk(!m_valid && buf_level == 2'd0, "t6_rst_flush", m_valid, 0);
    tick(); rst = 1'b0; fifo_clr = 1'b0; m_ready = 1'b1;

    // narrow counter wrap
    write_words(17, 8'h40);
    wait_drain("t6_wrap_drain");
    @(negedge clk);
    chk(words_out4 == 4'd1, "t6_wrap4", words_out4, 1);
    chk(words_out == 16'd17, "t6_words17", words_out, 17);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
